// File: rtl/dsp_mac_if.sv
// dsp_mac_if: operand and result streaming bundle for dsp_mac.
// The master modport is the producer/consumer side (drives operands and
// out_ready); the slave modport is the MAC itself.
interface dsp_mac_if #(
    parameter int width     = 16,
    parameter int acc_width = 48
);
    logic                        in_valid;
    logic                        in_ready;
    logic signed [width-1:0]     a;
    logic signed [width-1:0]     b;
    logic                        in_last;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [acc_width-1:0] y;

    modport master (
        output in_valid, a, b, in_last, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, a, b, in_last, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/dsp_mac.sv
// dsp_mac: three-stage pipelined signed multiply-accumulate with valid/ready
// streaming. Each vector (terminated by in_last) yields one dot-product on y.
// A single global advance freezes the whole pipe while a result waits.
// Optional feature: define DSP_MAC_SATURATE_EN to clamp the accumulation on
// signed overflow instead of wrapping modulo 2^acc_width.
module dsp_mac #(
    parameter int width     = 16,
    parameter int acc_width = 48
) (
    input  logic       clock,
    input  logic       reset,
    dsp_mac_if.slave   bus
);

    logic                        adv;

    logic                        s1_valid_q, s1_valid_d;
    logic signed [width-1:0]     s1_a_q, s1_a_d;
    logic signed [width-1:0]     s1_b_q, s1_b_d;
    logic                        s1_last_q, s1_last_d;

    logic                        s2_valid_q, s2_valid_d;
    logic signed [acc_width-1:0] s2_p_q, s2_p_d;
    logic                        s2_last_q, s2_last_d;

    logic signed [acc_width-1:0] acc_q, acc_d;
    logic signed [acc_width-1:0] y_q, y_d;
    logic                        out_valid_q, out_valid_d;

    logic signed [2*width-1:0]   prod;
    logic signed [acc_width-1:0] sum_raw;
    logic signed [acc_width-1:0] sum;

    // Whole pipe moves unless a finished result is sitting unconsumed.
    assign adv          = !(out_valid_q && !bus.out_ready);
    assign bus.in_ready = adv;
    assign bus.out_valid = out_valid_q;
    assign bus.y         = y_q;

    // Stage 1: capture the operand beat.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_last_d  = s1_last_q;
        if (adv) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_a_d    = bus.a;
                s1_b_d    = bus.b;
                s1_last_d = bus.in_last;
            end
        end
    end

    // Stage 2: signed product, sign-extended to the accumulator width.
    always_comb begin
        prod       = s1_a_q * s1_b_q;
        s2_valid_d = s2_valid_q;
        s2_p_d     = s2_p_q;
        s2_last_d  = s2_last_q;
        if (adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_p_d    = acc_width'(prod);
                s2_last_d = s1_last_q;
            end
        end
    end

`ifdef DSP_MAC_SATURATE_EN
    // Accumulate with clamping: overflow only when both addends share a sign
    // and the raw sum's sign differs from it.
    always_comb begin
        sum_raw = acc_q + s2_p_q;
        sum     = sum_raw;
        if (!acc_q[acc_width-1] && !s2_p_q[acc_width-1] && sum_raw[acc_width-1]) begin
            sum = {1'b0, {(acc_width-1){1'b1}}};
        end else if (acc_q[acc_width-1] && s2_p_q[acc_width-1] && !sum_raw[acc_width-1]) begin
            sum = {1'b1, {(acc_width-1){1'b0}}};
        end
    end
`else
    // Accumulate with plain two's-complement wraparound.
    always_comb begin
        sum_raw = acc_q + s2_p_q;
        sum     = sum_raw;
    end
`endif

    // Stage 3: fold the product into acc; a last beat publishes and clears.
    always_comb begin
        acc_d       = acc_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        if (adv) begin
            // adv implies any held result is being taken this edge.
            out_valid_d = 1'b0;
            if (s2_valid_q) begin
                if (s2_last_q) begin
                    y_d         = sum;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                end else begin
                    acc_d = sum;
                end
            end
        end
    end

    // State registers; reset discards in-flight beats and partial sums.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_last_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_p_q      <= '0;
            s2_last_q   <= 1'b0;
            acc_q       <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_last_q   <= s1_last_d;
            s2_valid_q  <= s2_valid_d;
            s2_p_q      <= s2_p_d;
            s2_last_q   <= s2_last_d;
            acc_q       <= acc_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_dsp_mac.sv
// tb_dsp_mac: directed bench for dsp_mac. A 32x32->64 instance covers the
// streaming behaviour; an 8x8->16 instance covers accumulator overflow.
module tb_dsp_mac;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    dsp_mac_if #(.width(32), .acc_width(64)) bw ();
    dsp_mac_if #(.width(8),  .acc_width(16)) bo ();

    dsp_mac #(.width(32), .acc_width(64)) u_wide (
        .clock (clk),
        .reset (rst_n),
        .bus   (bw)
    );

    dsp_mac #(.width(8), .acc_width(16)) u_ovf (
        .clock (clk),
        .reset (rst_n),
        .bus   (bo)
    );

    int          checks = 0;
    int          errors = 0;
    longint      q[$];
    bit          fire;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: note handshakes visible before the rising edge, then land
    // on the following falling edge.
    task automatic step();
        fire = bw.in_valid && bw.in_ready;
        if (bw.out_valid && bw.out_ready) q.push_back(longint'(bw.y));
        @(negedge clk);
    endtask

    task automatic beat(input int av, input int bv, input logic last);
        bw.in_valid = 1'b1;
        bw.a        = av;
        bw.b        = bv;
        bw.in_last  = last;
        step();
        bw.in_valid = 1'b0;
        bw.in_last  = 1'b0;
    endtask

    task automatic wait_out(input int maxc);
        int n = 0;
        while (!bw.out_valid && n < maxc) begin
            step();
            n++;
        end
        chk("wait_out_valid", 64'(bw.out_valid), 64'd1);
    endtask

    initial begin
        int          ba[5];
        int          bb[5];
        logic        bl[5];
        longint      expq[$];
        longint      macc;
        int          idx;
        int          held;
        logic [63:0] held_y;
        int          n;

        ba = '{1, 2, 3, 4, 5};
        bb = '{1, 2, 3, 4, 5};
        bl = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

        rst_n        = 1'b0;
        bw.in_valid  = 1'b0;
        bw.a         = '0;
        bw.b         = '0;
        bw.in_last   = 1'b0;
        bw.out_ready = 1'b1;
        bo.in_valid  = 1'b0;
        bo.a         = '0;
        bo.b         = '0;
        bo.in_last   = 1'b0;
        bo.out_ready = 1'b1;

        @(negedge clk);
        chk("rst_out_valid", 64'(bw.out_valid), 64'd0);
        chk("rst_y",         bw.y,              64'd0);
        chk("rst_in_ready",  64'(bw.in_ready),  64'd1);
        chk("rst_ovf_valid", 64'(bo.out_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single beat: -255 * 3, result after the third edge.
        bw.in_valid = 1'b1;
        bw.a        = -255;
        bw.b        = 3;
        bw.in_last  = 1'b1;
        chk("single_in_ready", 64'(bw.in_ready), 64'd1);
        step();
        bw.in_valid = 1'b0;
        bw.in_last  = 1'b0;
        chk("lat_edge1", 64'(bw.out_valid), 64'd0);
        step();
        chk("lat_edge2", 64'(bw.out_valid), 64'd0);
        step();
        chk("lat_edge3", 64'(bw.out_valid), 64'd1);
        chk("single_y",  bw.y, -64'sd765);
        step();
        chk("single_popped", 64'(bw.out_valid), 64'd0);

        // Three-beat vector then a one-beat vector.
        q.delete();
        beat(1, 2, 1'b0);
        beat(3, 4, 1'b0);
        beat(5, 6, 1'b1);
        repeat (5) step();
        chk("vec_count", 64'(q.size()), 64'd1);
        chk("vec_y",     64'(q[0]),     64'd44);
        beat(7, 1, 1'b1);
        repeat (4) step();
        chk("vec2_count", 64'(q.size()), 64'd2);
        chk("vec2_y",     64'(q[1]),     64'd7);

        // Bubble inside a vector leaves acc alone.
        q.delete();
        beat(1, 1, 1'b0);
        step();
        beat(2, 2, 1'b1);
        repeat (5) step();
        chk("bubble_count", 64'(q.size()), 64'd1);
        chk("bubble_y",     64'(q[0]),     64'd5);

        // Back-to-back last beats: one result per cycle.
        beat(2, 3, 1'b1);
        beat(4, 5, 1'b1);
        beat(-1, 1, 1'b1);
        chk("b2b_v0", 64'(bw.out_valid), 64'd1);
        chk("b2b_y0", bw.y, 64'd6);
        step();
        chk("b2b_v1", 64'(bw.out_valid), 64'd1);
        chk("b2b_y1", bw.y, 64'd20);
        step();
        chk("b2b_v2", 64'(bw.out_valid), 64'd1);
        chk("b2b_y2", bw.y, -64'sd1);
        step();
        chk("b2b_done", 64'(bw.out_valid), 64'd0);

        // Backpressure: stall the first result for four cycles.
        expq.delete();
        macc = 0;
        for (int k = 0; k < 5; k++) begin
            macc += longint'(ba[k]) * longint'(bb[k]);
            if (bl[k]) begin
                expq.push_back(macc);
                macc = 0;
            end
        end
        q.delete();
        idx          = 0;
        held         = 0;
        held_y       = '0;
        bw.out_ready = 1'b0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (idx == 5 && q.size() == 3) break;
            bw.in_valid = (idx < 5);
            if (idx < 5) begin
                bw.a       = ba[idx];
                bw.b       = bb[idx];
                bw.in_last = bl[idx];
            end
            if (held < 4) begin
                if (bw.out_valid) begin
                    chk("bp_in_ready", 64'(bw.in_ready), 64'd0);
                    if (held == 0) held_y = bw.y;
                    else           chk("bp_y_stable", bw.y, held_y);
                    held++;
                end
                bw.out_ready = 1'b0;
            end else begin
                bw.out_ready = 1'b1;
            end
            step();
            if (fire) idx++;
        end
        bw.in_valid  = 1'b0;
        bw.in_last   = 1'b0;
        bw.out_ready = 1'b1;
        chk("bp_stall_seen",    64'(held),     64'd4);
        chk("bp_all_accepted",  64'(idx),      64'd5);
        chk("bp_result_count",  64'(q.size()), 64'(expq.size()));
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_y%0d", k), 64'(q[k]), 64'(expq[k]));
        end

        // Overflow on the narrow instance: 3 * 127 * 127 = 48387.
        bo.in_valid = 1'b1;
        bo.a        = 8'sd127;
        bo.b        = 8'sd127;
        bo.in_last  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bo.in_last  = 1'b1;
        @(negedge clk);
        bo.in_valid = 1'b0;
        bo.in_last  = 1'b0;
        n = 0;
        while (!bo.out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("ovf_valid", 64'(bo.out_valid), 64'd1);
`ifdef DSP_MAC_SATURATE_EN
        chk("ovf_y", {48'd0, bo.y}, 64'h7FFF);
`else
        chk("ovf_y", {48'd0, bo.y}, 64'hBD03);
`endif

        // Reset mid-vector discards the partial sum and in-flight beats.
        beat(10, 10, 1'b0);
        beat(10, 10, 1'b0);
        step();
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid_now", 64'(bw.out_valid), 64'd0);
        @(negedge clk);
        chk("rstmid_valid_held", 64'(bw.out_valid), 64'd0);
        rst_n = 1'b1;
        beat(2, 2, 1'b1);
        wait_out(6);
        chk("rstmid_y", bw.y, 64'd4);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
